// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: nibble-serial sequencer that streams a state word through one
// shared external 4-bit S-box, LANES nibbles per cycle, with valid/ready on both sides.
`default_nettype none

module sbox_layer_seq #(
    parameter int NIBBLES = 16,
    parameter int LANES   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_data,
    output logic [4*LANES-1:0]   sbox_in,
    input  logic [4*LANES-1:0]   sbox_out,
    output logic                 busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int STEPS = NIBBLES / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (LANES < 1 || LANES > NIBBLES) begin : g_bad_lanes
            $error("sbox_layer_seq: LANES must be in 1..NIBBLES");
        end else if ((NIBBLES % LANES) != 0) begin : g_bad_divide
            $error("sbox_layer_seq: LANES must divide NIBBLES");
        end
    endgenerate

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sreg;
    logic [W-1:0]  next_sreg;

    // Substituted lanes enter at the MSB end, so after STEPS shifts the word is back in order.
    generate
        if (NIBBLES == LANES) begin : g_single_step
            assign next_sreg = sbox_out;
        end else begin : g_shift_step
            assign next_sreg = {sbox_out, sreg[W-1:4*LANES]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else if (clear) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg  <= in_data;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sreg <= next_sreg;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign out_data  = sreg;
    assign sbox_in   = sreg[4*LANES-1:0];

endmodule

`default_nettype wire

// File: tb/tb_sbox_layer_seq.sv
// tb_sbox_layer_seq: directed checks of sbox_layer_seq with one lane and four lanes,
// both fed by a golden 4-bit S-box model.
`default_nettype none

module tb_sbox_layer_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear, in_valid, out_ready;
    logic [63:0] in_data;
    logic        in_ready, out_valid, busy;
    logic [63:0] out_data;
    logic [3:0]  sbox_in, sbox_out;

    logic        clear4, in_valid4, out_ready4;
    logic [63:0] in_data4;
    logic        in_ready4, out_valid4, busy4;
    logic [63:0] out_data4;
    logic [15:0] sbox_in4, sbox_out4;

    int errors = 0;
    int checks = 0;

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: sb = 4'h0;  4'h1: sb = 4'h6;  4'h2: sb = 4'hE;  4'h3: sb = 4'h1;
            4'h4: sb = 4'hF;  4'h5: sb = 4'h4;  4'h6: sb = 4'h7;  4'h7: sb = 4'hD;
            4'h8: sb = 4'h9;  4'h9: sb = 4'h8;  4'hA: sb = 4'hC;  4'hB: sb = 4'h5;
            4'hC: sb = 4'h2;  4'hD: sb = 4'hA;  4'hE: sb = 4'h3;  default: sb = 4'hB;
        endcase
    endfunction

    function automatic logic [63:0] sub64(input logic [63:0] x);
        logic [63:0] r;
        for (int k = 0; k < 16; k++) r[4*k +: 4] = sb(x[4*k +: 4]);
        return r;
    endfunction

    assign sbox_out  = sb(sbox_in);
    assign sbox_out4 = {sb(sbox_in4[15:12]), sb(sbox_in4[11:8]), sb(sbox_in4[7:4]), sb(sbox_in4[3:0])};

    sbox_layer_seq #(.NIBBLES(16), .LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sbox_in(sbox_in), .sbox_out(sbox_out), .busy(busy)
    );

    sbox_layer_seq #(.NIBBLES(16), .LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .sbox_in(sbox_in4), .sbox_out(sbox_out4), .busy(busy4)
    );

    task automatic test_reset();
        rst_n = 1'b0; clear = 0; in_valid = 0; out_ready = 0; in_data = '0;
        clear4 = 0; in_valid4 = 0; out_ready4 = 0; in_data4 = '0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (out_data !== 64'h0 || sbox_in !== 4'h0) begin
            errors++; $display("FAIL reset_data: got %h/%h expected 0/0", out_data, sbox_in);
        end
        checks++;
        if ({in_ready4, out_valid4, busy4} !== 3'b100 || sbox_in4 !== 16'h0) begin
            errors++; $display("FAIL reset_lanes4: got %b/%h expected 100/0", {in_ready4, out_valid4, busy4}, sbox_in4);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int rise = -1;
        int busy_cnt = 0;
        logic [63:0] got = '0;
        in_data = 64'h21; in_valid = 1; out_ready = 1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; in_data = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (busy) busy_cnt++;
            if (out_valid && rise < 0) begin rise = cyc; got = out_data; end
            @(negedge clk);
        end
        checks++;
        if (rise !== 17) begin
            errors++; $display("FAIL basic_latency: got %0d expected 17", rise);
        end
        checks++;
        if (got !== 64'hE6) begin
            errors++; $display("FAIL basic_data: got %h expected %h", got, 64'hE6);
        end
        // RUN occupies 16 cycles and DONE one more with out_ready high
        checks++;
        if (busy_cnt !== 17) begin
            errors++; $display("FAIL basic_busy_cycles: got %0d expected 17", busy_cnt);
        end
    endtask

    task automatic test_backpressure();
        int waited = 0;
        in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_data = 64'h0;
        while (!out_valid && waited < 40) begin @(negedge clk); waited++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_timeout: got out_valid %b expected 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 64'hBBBB_BBBB_BBBB_BBBB) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h expected v=1 r=0 d=bbbbbbbbbbbbbbbb", i, out_valid, in_ready, out_data);
            end
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_during_handshake: got %b expected 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_after_handshake: got r=%b v=%b expected r=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_multilane();
        int rise = -1;
        logic [63:0] got = '0;
        in_data4 = 64'h1111_2222_0000_0000; in_valid4 = 1; out_ready4 = 1;
        @(negedge clk);
        in_valid4 = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (out_valid4 && rise < 0) begin rise = cyc; got = out_data4; end
            @(negedge clk);
        end
        checks++;
        if (rise !== 5) begin
            errors++; $display("FAIL lanes4_latency: got %0d expected 5", rise);
        end
        checks++;
        if (got !== 64'h6666_EEEE_0000_0000) begin
            errors++; $display("FAIL lanes4_data: got %h expected 6666eeee00000000", got);
        end
    endtask

    task automatic test_clear();
        int seen = 0;
        int waited = 0;
        in_data = 64'h0123_4567_89AB_CDEF; in_valid = 1; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (7) @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_idle: got r=%b b=%b v=%b expected r=1 b=0 v=0", in_ready, busy, out_valid);
        end
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL clear_no_output: got %0d valid cycles expected 0", seen);
        end
        in_valid = 1; clear = 1; in_data = 64'h5555;
        @(negedge clk);
        in_valid = 0; clear = 0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL clear_blocks_capture: got busy %b expected 0", busy);
        end
        in_data = 64'h21; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        while (!out_valid && waited < 40) begin @(negedge clk); waited++; end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'hE6) begin
            errors++; $display("FAIL clear_next_word: got v=%b d=%h expected v=1 d=e6", out_valid, out_data);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int waited = 0;
        in_data = 64'h2222_1111_FFFF_0000; in_valid = 1; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        while (!out_valid && waited < 40) begin @(negedge clk); waited++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL areset_reach_done: got %b expected 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0) begin
            errors++; $display("FAIL areset_immediate: got v=%b r=%b d=%h expected v=0 r=1 d=0", out_valid, in_ready, out_data);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] words[100];
        int in_idx = 0;
        int out_idx = 0;
        int budget = 0;
        logic acc, fire;
        for (int i = 0; i < 100; i++) words[i] = {$urandom, $urandom};
        in_valid = 1;
        while (out_idx < 100 && budget < 6000) begin
            in_data = (in_idx < 100) ? words[in_idx] : 64'h0;
            in_valid = (in_idx < 100);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                checks++;
                if (out_data !== sub64(words[out_idx])) begin
                    errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", out_idx, out_data, sub64(words[out_idx]));
                end
                out_idx++;
            end
            @(negedge clk);
            if (acc) in_idx++;
            budget++;
        end
        in_valid = 0;
        checks++;
        if (out_idx !== 100 || in_idx !== 100) begin
            errors++; $display("FAIL b2b_count: got in=%0d out=%0d expected 100/100", in_idx, out_idx);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_no_duplicate: got out_valid %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_multilane();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
